cordic16_seq: RTL and testbench

- Initiator-side sequencer for the serial 16-bit CORDIC engine (load/rdy, mi/mo interface). Accepts x/y/z/mode samples on a valid/ready stream and issues exactly one CORDIC operation at a time.
- Catches each result on c_rdy, queues it, and presents it on a valid/ready output stream.
- Sits between sample-rate DSP stages (mixer, AM/phase demod) and the cordic16 instance, replacing hand-timed 40-cycle load strobes.

---
 rtl/cordic_pkg.sv | 21 ++
 rtl/cordic16_rfifo.sv | 73 +++++++
 rtl/cordic16_seq.sv | 181 ++++++++++++++++++
 tb/tb_cordic16_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types for the cordic16 sequencer: data width, sequencer state and
// the result record queued between the engine and the output stream.
package cordic_pkg;

    localparam int CW = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [CW-1:0] z;
        logic          m;
    } result_t;

    localparam int RW = $bits(result_t);

endpackage

// File: rtl/cordic16_rfifo.sv
// Show-ahead result FIFO: rdata always presents the head entry, pop advances it.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module cordic16_rfifo #(
    parameter int DEPTH = 4,
    parameter int W     = 49
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_MAX);
    assign count = count_q;
    assign rdata = empty ? '0 : mem_q[rd_q];

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_d = rd_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cordic16_seq.sv
// Initiator-side sequencer for the serial cordic16 engine: one op in flight,
// loads spaced by at least MIN_GAP cycles, results queued onto an output stream.
module cordic16_seq
    import cordic_pkg::*;
#(
    parameter int RDEPTH  = 4,
    parameter int TIMEOUT = 63,
    parameter int MIN_GAP = 40
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [CW-1:0] s_x,
    input  logic [CW-1:0] s_y,
    input  logic [CW-1:0] s_z,
    input  logic          s_m,
    output logic [CW-1:0] c_xi,
    output logic [CW-1:0] c_yi,
    output logic [CW-1:0] c_zi,
    output logic          c_mi,
    output logic          c_load,
    input  logic [CW-1:0] c_xo,
    input  logic [CW-1:0] c_yo,
    input  logic [CW-1:0] c_zo,
    input  logic          c_mo,
    input  logic          c_rdy,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [CW-1:0] m_x,
    output logic [CW-1:0] m_y,
    output logic [CW-1:0] m_z,
    output logic          m_m,
    output logic          busy,
    output logic          err_to,
    output logic          err_mode,
    output state_e        dbg_state
);

    localparam int CMAX = (TIMEOUT > MIN_GAP) ? TIMEOUT : MIN_GAP;
    localparam int CNTW = $clog2(CMAX + 1);
    localparam int FCW  = $clog2(RDEPTH) + 1;

    localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
    localparam logic [CNTW-1:0] GAP_SAT   = CNTW'(MIN_GAP);
    localparam logic [CNTW-1:0] GAP_OK_TH = CNTW'(MIN_GAP - 1);
    localparam logic [CNTW-1:0] WAIT_LAST = CNTW'(TIMEOUT - 1);
    localparam logic [FCW-1:0]  FIFO_CAP  = FCW'(RDEPTH);

    state_e          state_q, state_d;
    logic [CNTW-1:0] wait_q, wait_d;
    logic [CNTW-1:0] gap_q, gap_d;
    logic [CW-1:0]   c_xi_q, c_xi_d;
    logic [CW-1:0]   c_yi_q, c_yi_d;
    logic [CW-1:0]   c_zi_q, c_zi_d;
    logic            c_mi_q, c_mi_d;
    logic            c_load_q, c_load_d;
    logic            err_to_q, err_to_d;
    logic            err_mode_q, err_mode_d;

    logic            push;
    logic            pop;
    result_t         wdata;
    result_t         head;
    logic            fifo_empty;
    logic            fifo_full;
    logic [FCW-1:0]  fifo_count;

    // Both streams use valid/ready: a beat transfers on a rising edge where
    // valid and ready are both high; valid-side data is held until that edge.
    // The count check keeps a slot free for the result of the op about to launch.
    assign s_ready = rst_n && (state_q == IDLE) && (gap_q >= GAP_OK_TH)
                     && (fifo_count < FIFO_CAP);

    assign wdata = '{x: c_xo, y: c_yo, z: c_zo, m: c_mo};
    assign pop   = m_valid && m_ready;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        gap_d      = (gap_q < GAP_SAT) ? gap_q + CNT_ONE : gap_q;
        c_xi_d     = c_xi_q;
        c_yi_d     = c_yi_q;
        c_zi_d     = c_zi_q;
        c_mi_d     = c_mi_q;
        c_load_d   = 1'b0;
        err_to_d   = err_to_q;
        err_mode_d = err_mode_q;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_valid && s_ready) begin
                    c_xi_d   = s_x;
                    c_yi_d   = s_y;
                    c_zi_d   = s_z;
                    c_mi_d   = s_m;
                    c_load_d = 1'b1;
                    wait_d   = '0;
                    gap_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                wait_d = wait_q + CNT_ONE;
                // A result arriving on the last allowed cycle still wins over the timeout.
                if (c_rdy) begin
                    push    = 1'b1;
                    state_d = IDLE;
                    if (c_mo != c_mi_q) begin
                        err_mode_d = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    err_to_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            gap_q      <= GAP_SAT;
            c_xi_q     <= '0;
            c_yi_q     <= '0;
            c_zi_q     <= '0;
            c_mi_q     <= 1'b0;
            c_load_q   <= 1'b0;
            err_to_q   <= 1'b0;
            err_mode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            gap_q      <= gap_d;
            c_xi_q     <= c_xi_d;
            c_yi_q     <= c_yi_d;
            c_zi_q     <= c_zi_d;
            c_mi_q     <= c_mi_d;
            c_load_q   <= c_load_d;
            err_to_q   <= err_to_d;
            err_mode_q <= err_mode_d;
        end
    end

    cordic16_rfifo #(
        .DEPTH (RDEPTH),
        .W     (RW)
    ) u_rfifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign c_xi      = c_xi_q;
    assign c_yi      = c_yi_q;
    assign c_zi      = c_zi_q;
    assign c_mi      = c_mi_q;
    assign c_load    = c_load_q;
    assign m_valid   = !fifo_empty;
    assign m_x       = head.x;
    assign m_y       = head.y;
    assign m_z       = head.z;
    assign m_m       = head.m;
    assign busy      = (state_q == BUSY);
    assign err_to    = err_to_q;
    assign err_mode  = err_mode_q;
    assign dbg_state = state_q;

    // fifo_full is implied by the count check in s_ready; kept for bind-in checkers.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_cordic16_seq.sv
// Directed bench for cordic16_seq with a behavioural CORDIC engine model
// (xo=xi+1, yo=yi+2, zo=zi+3, mo=mi, c_rdy 38 cycles after load).
module tb_cordic16_seq;
    import cordic_pkg::*;

    logic          clk;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [15:0]   s_x, s_y, s_z;
    logic          s_m;
    logic [15:0]   c_xi, c_yi, c_zi;
    logic          c_mi;
    logic          c_load;
    logic [15:0]   c_xo, c_yo, c_zo;
    logic          c_mo;
    logic          c_rdy;
    logic          m_valid;
    logic          m_ready;
    logic [15:0]   m_x, m_y, m_z;
    logic          m_m;
    logic          busy;
    logic          err_to;
    logic          err_mode;
    state_e        dbg_state;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            model_mode = 0;   // 0 normal, 1 inverted mo, 2 late c_rdy
    int            load_q[$];
    logic [48:0]   exp_q[$];
    bit            c_done;

    cordic16_seq dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_x(s_x), .s_y(s_y), .s_z(s_z), .s_m(s_m),
        .c_xi(c_xi), .c_yi(c_yi), .c_zi(c_zi), .c_mi(c_mi), .c_load(c_load),
        .c_xo(c_xo), .c_yo(c_yo), .c_zo(c_zo), .c_mo(c_mo), .c_rdy(c_rdy),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_x(m_x), .m_y(m_y), .m_z(m_z), .m_m(m_m),
        .busy(busy), .err_to(err_to), .err_mode(err_mode),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- check ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- engine model ----------------
    initial begin
        c_rdy = 1'b0; c_xo = '0; c_yo = '0; c_zo = '0; c_mo = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (c_load) begin
                logic [15:0] x, y, z;
                logic m;
                int lat;
                x = c_xi; y = c_yi; z = c_zi; m = c_mi;
                lat = (model_mode == 2) ? 70 : 38;
                repeat (lat) @(posedge clk);
                #1;
                c_xo = x + 16'd1; c_yo = y + 16'd2; c_zo = z + 16'd3;
                c_mo = (model_mode == 1) ? ~m : m;
                c_rdy = 1'b1;
                @(posedge clk); #1;
                c_rdy = 1'b0;
            end
        end
    end

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin
        if (c_load) load_q.push_back(cyc);
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 64'({m_x, m_y, m_z, m_m}), 64'h0);
            end else begin
                logic [48:0] e;
                e = exp_q.pop_front();
                check("sb_result", 64'({m_x, m_y, m_z, m_m}), 64'(e));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    // Offers one sample, returns #1 into the cycle after acceptance (the load cycle).
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                        input logic m, input bit exp_en, input logic mo_exp);
        int n;
        logic [15:0] ex, ey, ez;
        s_x = x; s_y = y; s_z = z; s_m = m; s_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("s_ready_wait", 64'(s_ready), 64'h1);
        ex = x + 16'd1; ey = y + 16'd2; ez = z + 16'd3;
        if (exp_en) exp_q.push_back({ex, ey, ez, mo_exp});
        @(posedge clk); #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_done", 64'(exp_q.size()), 64'h0);
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] bx[5] = '{16'h0001, 16'h7FFF, 16'h8000, 16'h1234, 16'hFFFE};
    logic [15:0] by[5] = '{16'h0010, 16'h0000, 16'hFFFF, 16'hABCD, 16'h4000};
    logic [15:0] bz[5] = '{16'h0100, 16'hFFFC, 16'h2000, 16'h5555, 16'h0000};
    logic        bm[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int l, n, p;
        rst_n = 1'b0; s_valid = 1'b0; s_x = '0; s_y = '0; s_z = '0; s_m = 1'b0;
        m_ready = 1'b0; c_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 64'(s_ready), 64'h0);
        check("rst_outputs", 64'({c_load, busy, m_valid, err_to, err_mode, c_mi}), 64'h0);
        check("rst_operands", 64'({c_xi, c_yi, c_zi}), 64'h0);
        check("rst_m_data", 64'({m_x, m_y, m_z, m_m}), 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_s_ready", 64'(s_ready), 64'h1);

        // A: single op, latency and data
        send(16'h4000, 16'hC000, 16'h0000, 1'b1, 1'b0, 1'b0);
        l = cyc;
        check("a_c_load", 64'(c_load), 64'h1);
        check("a_operands", 64'({c_xi, c_yi, c_zi, c_mi}), 64'({16'h4000, 16'hC000, 16'h0000, 1'b1}));
        check("a_busy", 64'(busy), 64'h1);
        check("a_dbg_state", 64'(dbg_state), 64'(BUSY));
        s_valid = 1'b0;
        @(posedge clk); #1;
        check("a_c_load_pulse", 64'(c_load), 64'h0);
        n = 1;
        while (!m_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("a_result_latency", 64'(n), 64'd39);
        check("a_m_x", 64'(m_x), 64'd16385);
        check("a_m_y", 64'(m_y), 64'(16'hC002));
        check("a_m_z", 64'(m_z), 64'd3);
        check("a_m_m", 64'(m_m), 64'h1);
        check("a_busy_low", 64'(busy), 64'h0);
        check("a_operands_hold", 64'(c_xi), 64'(16'h4000));
        exp_q.push_back({16'h4001, 16'hC002, 16'h0003, 1'b1});
        m_ready = 1'b1;
        drain(20);
        check("a_m_valid_after_pop", 64'(m_valid), 64'h0);

        // B: back-to-back samples, load spacing
        goto(l + 60);
        load_q.delete();
        for (int i = 0; i < 5; i++) send(bx[i], by[i], bz[i], bm[i], 1'b1, bm[i]);
        s_valid = 1'b0;
        drain(200);
        check("b_load_count", 64'(load_q.size()), 64'd5);
        for (int i = 1; i < 5 && i < load_q.size(); i++)
            check("b_load_spacing", 64'(load_q[i] - load_q[i-1]), 64'd40);
        check("b_errors", 64'({err_to, err_mode}), 64'h0);

        // C: backpressure, FIFO full holds off loads
        goto(cyc + 10);
        m_ready = 1'b0;
        load_q.delete();
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(16'(i * 16'h0111), 16'(16'hF000 + i), 16'(i), i[0], 1'b1, i[0]);
                s_valid = 1'b0;
                c_done = 1'b1;
            end
        join_none
        goto(cyc + 240);
        check("c_load_count", 64'(load_q.size()), 64'd4);
        check("c_s_ready_full", 64'(s_ready), 64'h0);
        check("c_m_valid", 64'(m_valid), 64'h1);
        m_ready = 1'b1;
        p = cyc;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check("c_no_load_yet", 64'(c_load), 64'h0);
        check("c_s_ready_freed", 64'(s_ready), 64'h1);
        goto(p + 2);
        check("c_fifth_load", 64'(c_load), 64'h1);
        m_ready = 1'b1;
        n = 0;
        while (!c_done && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("c_sender_done", 64'(c_done), 64'h1);
        drain(200);
        check("c_total_loads", 64'(load_q.size()), 64'd6);

        // D: timeout, then a late c_rdy that must be ignored
        goto(cyc + 45);
        model_mode = 2;
        send(16'h0AAA, 16'h0BBB, 16'h0CCC, 1'b0, 1'b0, 1'b0);
        s_valid = 1'b0;
        l = cyc;
        goto(l + 62);
        check("d_err_to_before", 64'(err_to), 64'h0);
        check("d_busy_before", 64'(busy), 64'h1);
        goto(l + 63);
        check("d_err_to_set", 64'(err_to), 64'h1);
        check("d_busy_cleared", 64'(busy), 64'h0);
        check("d_s_ready_after", 64'(s_ready), 64'h1);
        goto(l + 75);
        check("d_late_ignored", 64'(m_valid), 64'h0);
        check("d_err_mode_clear", 64'(err_mode), 64'h0);
        model_mode = 0;
        send(16'h0001, 16'h0002, 16'h0003, 1'b1, 1'b1, 1'b1);
        s_valid = 1'b0;
        drain(60);
        check("d_err_to_sticky", 64'(err_to), 64'h1);

        // E: mode mismatch returned by engine
        goto(cyc + 45);
        model_mode = 1;
        send(16'h2222, 16'h3333, 16'h4444, 1'b0, 1'b1, 1'b1);
        s_valid = 1'b0;
        check("e_err_mode_before", 64'(err_mode), 64'h0);
        drain(60);
        check("e_err_mode_set", 64'(err_mode), 64'h1);
        model_mode = 0;

        // F: reset mid-operation
        goto(cyc + 45);
        send(16'h5555, 16'h6666, 16'h7777, 1'b1, 1'b0, 1'b0);
        s_valid = 1'b0;
        l = cyc;
        goto(l + 20);
        rst_n = 1'b0;
        #2;
        check("f_async_ctrl", 64'({c_load, busy, m_valid, err_to, err_mode, c_mi}), 64'h0);
        check("f_async_operands", 64'({c_xi, c_yi, c_zi}), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        goto(l + 45);
        check("f_stray_rdy_m_valid", 64'(m_valid), 64'h0);
        check("f_stray_rdy_busy", 64'(busy), 64'h0);
        check("f_exp_empty", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
